// File: rtl/histogram_accumulator.sv
// Streams NUM_WORDS*PPW pixels from a source memory and builds their histogram
// in an external bin memory, one pixel per clock, with read-modify-write forwarding.
module histogram_accumulator #(
  parameter int PIX_W     = 8,
  parameter int PPW       = 16,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic                            clock,
  input  logic                            rst_n,
  input  logic                            start,
  output logic [ADDR_W-1:0]               src_addr,
  input  logic [PPW*PIX_W-1:0]            src_data,
  output logic [PIX_W-1:0]                bin_raddr,
  input  logic [CNT_W-1:0]                bin_rdata,
  output logic [PIX_W-1:0]                bin_waddr,
  output logic [CNT_W-1:0]                bin_wdata,
  output logic                            bin_we,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_W+$clog2(PPW)-1:0]   pix_total
);

  localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int TOT_W = ADDR_W + $clog2(PPW);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_srcAddr;
  logic [IDX_W-1:0]   r_pixIdx;
  logic               r_s1Valid;
  logic [IDX_W-1:0]   r_s1Idx;
  logic               r_s2Valid;
  logic [PIX_W-1:0]   r_s2Pix;
  logic               r_binWe;
  logic [PIX_W-1:0]   r_binWaddr;
  logic [CNT_W-1:0]   r_binWdata;
  logic               r_wrValid;
  logic [PIX_W-1:0]   r_wrPix;
  logic [CNT_W-1:0]   r_wrCnt;
  logic [TOT_W-1:0]   r_pixTotal;

  logic [PIX_W-1:0]   w_s1Pix;
  logic [CNT_W-1:0]   w_s2Base;
  logic [CNT_W-1:0]   w_s2Next;
  logic               w_lastIssue;

  assign w_s1Pix     = src_data[r_s1Idx*PIX_W +: PIX_W];
  assign w_lastIssue = (r_srcAddr == ADDR_W'(NUM_WORDS-1)) && (r_pixIdx == IDX_W'(PPW-1));

  // The bin memory returns old data when read and written in the same cycle, so
  // the write retired one cycle earlier (r_wr*) is also forwarded behind the S3 path.
  always_comb begin
    w_s2Base = bin_rdata;
    if (r_binWe && (r_binWaddr == r_s2Pix))
      w_s2Base = r_binWdata;
    else if (r_wrValid && (r_wrPix == r_s2Pix))
      w_s2Base = r_wrCnt;
  end

  assign w_s2Next = (w_s2Base == {CNT_W{1'b1}}) ? w_s2Base : w_s2Base + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_srcAddr  <= '0;
      r_pixIdx   <= '0;
      r_s1Valid  <= 1'b0;
      r_s1Idx    <= '0;
      r_s2Valid  <= 1'b0;
      r_s2Pix    <= '0;
      r_binWe    <= 1'b0;
      r_binWaddr <= '0;
      r_binWdata <= '0;
      r_wrValid  <= 1'b0;
      r_wrPix    <= '0;
      r_wrCnt    <= '0;
      r_pixTotal <= '0;
    end else begin
      r_s1Valid  <= 1'b0;
      r_s2Valid  <= r_s1Valid;
      r_s2Pix    <= w_s1Pix;
      r_binWe    <= r_s2Valid;
      r_binWaddr <= r_s2Pix;
      r_binWdata <= w_s2Next;
      r_wrValid  <= r_binWe;
      r_wrPix    <= r_binWaddr;
      r_wrCnt    <= r_binWdata;
      if (r_binWe && start && (r_state == RUN || r_state == DRAIN))
        r_pixTotal <= r_pixTotal + TOT_W'(1);

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= CLEAR;
            r_binWe    <= 1'b1;
            r_binWaddr <= '0;
            r_binWdata <= '0;
            r_srcAddr  <= '0;
            r_pixIdx   <= '0;
            r_pixTotal <= '0;
          end
        end
        CLEAR: begin
          if (!start) begin
            r_state   <= IDLE;
            r_s2Valid <= 1'b0;
            r_binWe   <= 1'b0;
          end else if (r_binWaddr == {PIX_W{1'b1}}) begin
            r_state <= RUN;
            r_binWe <= 1'b0;
          end else begin
            r_binWe    <= 1'b1;
            r_binWaddr <= r_binWaddr + PIX_W'(1);
            r_binWdata <= '0;
          end
        end
        RUN: begin
          if (!start) begin
            r_state   <= IDLE;
            r_s2Valid <= 1'b0;
            r_binWe   <= 1'b0;
          end else begin
            r_s1Valid <= 1'b1;
            r_s1Idx   <= r_pixIdx;
            if (w_lastIssue) begin
              r_state <= DRAIN;
            end else if (r_pixIdx == IDX_W'(PPW-1)) begin
              r_pixIdx  <= '0;
              r_srcAddr <= r_srcAddr + ADDR_W'(1);
            end else begin
              r_pixIdx <= r_pixIdx + IDX_W'(1);
            end
          end
        end
        // The S3 write of the final pixel retires on the same edge that enters DONE.
        DRAIN: begin
          if (!start) begin
            r_state   <= IDLE;
            r_s2Valid <= 1'b0;
            r_binWe   <= 1'b0;
          end else if (!r_s1Valid && !r_s2Valid) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!start) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign src_addr  = r_srcAddr;
  assign bin_raddr = r_s1Valid ? w_s1Pix : '0;
  assign bin_waddr = r_binWaddr;
  assign bin_wdata = r_binWdata;
  assign bin_we    = r_binWe;
  assign busy      = (r_state == CLEAR) || (r_state == RUN) || (r_state == DRAIN);
  assign done      = (r_state == DONE);
  assign pix_total = r_pixTotal;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Self-checking bench for histogram_accumulator: table-driven frames on a default
// instance plus abort, reset-in-DRAIN and saturation sequences.
module tb_histogram_accumulator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n, start, start2;

  logic [15:0]  srcAddr;
  logic [127:0] srcData;
  logic [7:0]   binRaddr, binWaddr;
  logic [15:0]  binRdata, binWdata;
  logic         binWe, busy, done;
  logic [19:0]  pixTotal;

  logic [7:0]   srcAddr2;
  logic [31:0]  srcData2;
  logic [7:0]   binRaddr2, binWaddr2;
  logic [3:0]   binRdata2, binWdata2;
  logic         binWe2, busy2, done2;
  logic [9:0]   pixTotal2;

  logic [127:0] srcMem [4];
  logic [15:0]  binMem [256];
  logic [31:0]  srcMem2 [8];
  logic [3:0]   binMem2 [256];

  int errors = 0;
  int checks = 0;

  histogram_accumulator dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .src_addr(srcAddr), .src_data(srcData),
    .bin_raddr(binRaddr), .bin_rdata(binRdata),
    .bin_waddr(binWaddr), .bin_wdata(binWdata), .bin_we(binWe),
    .busy(busy), .done(done), .pix_total(pixTotal)
  );

  histogram_accumulator #(.PIX_W(8), .PPW(4), .NUM_WORDS(5), .ADDR_W(8), .CNT_W(4)) dutSat (
    .clock(clock), .rst_n(rst_n), .start(start2),
    .src_addr(srcAddr2), .src_data(srcData2),
    .bin_raddr(binRaddr2), .bin_rdata(binRdata2),
    .bin_waddr(binWaddr2), .bin_wdata(binWdata2), .bin_we(binWe2),
    .busy(busy2), .done(done2), .pix_total(pixTotal2)
  );

  // Memory models: 1-cycle read latency, reads return pre-write data; bins are
  // filled with junk during reset so the CLEAR phase is actually observed.
  always @(posedge clock) begin
    srcData  <= srcMem[srcAddr[1:0]];
    binRdata <= binMem[binRaddr];
    srcData2 <= srcMem2[srcAddr2[2:0]];
    binRdata2 <= binMem2[binRaddr2];
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        binMem[i]  <= 16'hBEEF;
        binMem2[i] <= 4'hA;
      end
    end else begin
      if (binWe)  binMem[binWaddr]   <= binWdata;
      if (binWe2) binMem2[binWaddr2] <= binWdata2;
    end
  end

  typedef struct {
    string name;
    int    mode;
    int    binA, expA;
    int    binB, expB;
    int    binC, expC;
    int    expTotal;
  } vec_t;

  vec_t vecs [4];
  int   model [256];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] pixelOf(input int mode, input int n);
    case (mode)
      0:       return 8'h05;
      1:       return 8'(n);
      2:       return (n % 2 == 1) ? 8'h22 : 8'h11;
      default: return (n % 4 == 2) ? 8'h22 : 8'h11;
    endcase
  endfunction

  // Loads the source frame and builds the reference histogram by plain counting.
  task automatic loadFrame(input int mode);
    for (int i = 0; i < 256; i++) model[i] = 0;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 16; k++) begin
        srcMem[w][k*8 +: 8] = pixelOf(mode, w*16 + k);
        model[pixelOf(mode, w*16 + k)]++;
      end
    end
  endtask

  task automatic applyStimulus(input int mode, output int cycles);
    loadFrame(mode);
    start  = 1'b1;
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(posedge clock); #1;
      cycles++;
    end
    checkOutput("doneReached", {31'd0, done}, 32'd1);
  endtask

  task automatic checkHistogram(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (binMem[i] !== model[i][15:0]) bad++;
    checkOutput(name, bad, 0);
  endtask

  task automatic finishFrame();
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checkOutput("doneHeld", {31'd0, done}, 32'd1);
    end
    start = 1'b0;
    @(posedge clock); #1;
    checkOutput("doneDropped", {31'd0, done}, 32'd0);
    checkOutput("idleBusy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cycles;
    int weSeen;

    vecs[0] = '{name: "allFive",   mode: 0, binA: 5,    expA: 64, binB: 0,    expB: 0,  binC: 6,    expC: 0, expTotal: 64};
    vecs[1] = '{name: "ascending", mode: 1, binA: 0,    expA: 1,  binB: 63,   expB: 1,  binC: 64,   expC: 0, expTotal: 64};
    vecs[2] = '{name: "altAB",     mode: 2, binA: 8'h11, expA: 32, binB: 8'h22, expB: 32, binC: 8'h12, expC: 0, expTotal: 64};
    vecs[3] = '{name: "AABA",      mode: 3, binA: 8'h11, expA: 48, binB: 8'h22, expB: 16, binC: 0,    expC: 0, expTotal: 64};

    rst_n  = 1'b0;
    start  = 1'b1;
    start2 = 1'b0;
    for (int w = 0; w < 8; w++) srcMem2[w] = 32'h33333333;
    loadFrame(0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstSrcAddr",  32'(srcAddr),  0);
    checkOutput("rstBinRaddr", 32'(binRaddr), 0);
    checkOutput("rstBinWaddr", 32'(binWaddr), 0);
    checkOutput("rstBinWdata", 32'(binWdata), 0);
    checkOutput("rstPixTotal", 32'(pixTotal), 0);
    checkOutput("rstBinWe",    {31'd0, binWe}, 0);
    checkOutput("rstBusy",     {31'd0, busy},  0);
    checkOutput("rstDone",     {31'd0, done},  0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clock); #1;

    for (int v = 0; v < 4; v++) begin
      $display("[TB] frame %s", vecs[v].name);
      applyStimulus(vecs[v].mode, cycles);
      checkOutput({vecs[v].name, "_cycles"}, cycles, 324);
      checkOutput({vecs[v].name, "_binA"}, 32'(binMem[vecs[v].binA]), vecs[v].expA);
      checkOutput({vecs[v].name, "_binB"}, 32'(binMem[vecs[v].binB]), vecs[v].expB);
      checkOutput({vecs[v].name, "_binC"}, 32'(binMem[vecs[v].binC]), vecs[v].expC);
      checkOutput({vecs[v].name, "_total"}, 32'(pixTotal), vecs[v].expTotal);
      checkOutput({vecs[v].name, "_weInDone"}, {31'd0, binWe}, 0);
      checkOutput({vecs[v].name, "_busyInDone"}, {31'd0, busy}, 0);
      checkHistogram({vecs[v].name, "_full"});
      finishFrame();
    end

    $display("[TB] abort mid-RUN then restart");
    loadFrame(2);
    start = 1'b1;
    repeat (300) begin @(posedge clock); #1; end
    checkOutput("abortBusyBefore", {31'd0, busy}, 1);
    start = 1'b0;
    @(posedge clock); #1;
    checkOutput("abortBusy", {31'd0, busy},  0);
    checkOutput("abortDone", {31'd0, done},  0);
    checkOutput("abortWe",   {31'd0, binWe}, 0);
    @(posedge clock); #1;
    checkOutput("abortWeHeld", {31'd0, binWe}, 0);
    applyStimulus(3, cycles);
    checkOutput("restartBinA", 32'(binMem[8'h11]), 48);
    checkOutput("restartBinB", 32'(binMem[8'h22]), 16);
    checkOutput("restartTotal", 32'(pixTotal), 64);
    checkHistogram("restartFull");
    finishFrame();

    $display("[TB] reset mid-DRAIN");
    loadFrame(0);
    start = 1'b1;
    repeat (321) begin @(posedge clock); #1; end
    checkOutput("drainBusy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #2;
    checkOutput("asyncNoEffect", {31'd0, busy}, 1);
    @(posedge clock); #1;
    checkOutput("drainRstSrcAddr",  32'(srcAddr),  0);
    checkOutput("drainRstBinRaddr", 32'(binRaddr), 0);
    checkOutput("drainRstBinWaddr", 32'(binWaddr), 0);
    checkOutput("drainRstBinWdata", 32'(binWdata), 0);
    checkOutput("drainRstPixTotal", 32'(pixTotal), 0);
    checkOutput("drainRstWe",       {31'd0, binWe}, 0);
    checkOutput("drainRstBusy",     {31'd0, busy},  0);
    checkOutput("drainRstDone",     {31'd0, done},  0);
    start = 1'b0;
    rst_n = 1'b1;
    weSeen = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (binWe) weSeen++;
    end
    checkOutput("drainRstNoWrites", weSeen, 0);

    $display("[TB] saturation with 4-bit counters");
    start2 = 1'b1;
    cycles = 0;
    while (!done2 && cycles < 2000) begin
      @(posedge clock); #1;
      cycles++;
    end
    checkOutput("satDone",   {31'd0, done2}, 1);
    checkOutput("satCycles", cycles, 280);
    checkOutput("satBin",    32'(binMem2[8'h33]), 15);
    checkOutput("satOther",  32'(binMem2[8'h34]), 0);
    checkOutput("satTotal",  32'(pixTotal2), 20);
    start2 = 1'b0;
    @(posedge clock); #1;
    checkOutput("satIdle", {31'd0, done2}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
